// File: rtl/vec_load_reg.sv
// DEPTH x DW vector register filled in order by a valid/ready stream, patchable
// by addressed writes, with a flat parallel output and full/done status for control.
module vec_load_reg #(
  parameter  int unsigned DW    = 8,
  parameter  int unsigned DEPTH = 21,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic [DEPTH*DW-1:0] vec_out,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        count_q;
  logic                 full_q;
  logic                 done_q;
  logic [DEPTH*DW-1:0]  vec_q;
  logic [DEPTH*DW-1:0]  vec_d;
  logic                 accept;

  always_comb begin
    in_ready = (state_q != ST_FULL) && !clr;
    accept   = in_valid && in_ready;
  end

  // Stream beat takes precedence on a shared entry; an address >= DEPTH matches no entry.
  always_comb begin
    vec_d = vec_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (accept && (count_q == CW'(i))) begin
        vec_d[i*DW +: DW] = in_data;
      end else if (wr_en && (wr_addr == AW'(i))) begin
        vec_d[i*DW +: DW] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      vec_q  <= vec_d;
      done_q <= 1'b0;
      if (accept) begin
        count_q <= count_q + CW'(1);
        case (state_q)
          ST_EMPTY: state_q <= ST_FILL;
          ST_FILL: begin
            if (count_q == CW'(DEPTH - 1)) begin
              state_q <= ST_FULL;
              full_q  <= 1'b1;
              done_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign vec_out = vec_q;
  assign count   = count_q;
  assign full    = full_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vec_load_reg.sv
// Directed bench for vec_load_reg: default 21x8 instance and a 4x16 instance.
module tb_vec_load_reg;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DW=8, DEPTH=21
  logic         a_rst, a_clr, a_in_valid, a_in_ready, a_wr_en, a_full, a_done;
  logic [7:0]   a_in_data, a_wr_data;
  logic [4:0]   a_wr_addr, a_count;
  logic [167:0] a_vec, expA;

  vec_load_reg #(.DW(8), .DEPTH(21)) dut_a (
    .clk(clk), .rst(a_rst), .clr(a_clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .vec_out(a_vec), .count(a_count), .full(a_full), .done(a_done)
  );

  // Instance B: DW=16, DEPTH=4
  logic         b_rst, b_clr, b_in_valid, b_in_ready, b_wr_en, b_full, b_done;
  logic [15:0]  b_in_data, b_wr_data;
  logic [1:0]   b_wr_addr;
  logic [2:0]   b_count;
  logic [63:0]  b_vec, expB;

  vec_load_reg #(.DW(16), .DEPTH(4)) dut_b (
    .clk(clk), .rst(b_rst), .clr(b_clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .vec_out(b_vec), .count(b_count), .full(b_full), .done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_clr = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    b_rst = 1'b1; b_clr = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    expA = '0; expB = '0;

    // ---------------- A1: reset then idle
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("A1 vec", a_vec, '0);
    chk("A1 count", 168'(a_count), 168'(0));
    chk("A1 full", 168'(a_full), 168'(0));
    chk("A1 done", 168'(a_done), 168'(0));
    chk("A1 in_ready", 168'(a_in_ready), 168'(1));

    // ---------------- A2: stream 21 beats 0x01..0x15
    a_in_valid = 1'b1;
    for (int i = 0; i < 21; i++) begin
      a_in_data = 8'(i + 1);
      tick();
      expA[i*8 +: 8] = 8'(i + 1);
      chk("A2 count", 168'(a_count), 168'(i + 1));
      if (i < 20) chk("A2 full low", 168'(a_full), 168'(0));
    end
    chk("A2 vec", a_vec, expA);
    chk("A2 full", 168'(a_full), 168'(1));
    chk("A2 done", 168'(a_done), 168'(1));
    chk("A2 in_ready", 168'(a_in_ready), 168'(0));

    // ---------------- A3: beat offered while full, then addressed write
    a_in_data = 8'hAA;
    tick();
    chk("A3 done drop", 168'(a_done), 168'(0));
    chk("A3 count", 168'(a_count), 168'(21));
    chk("A3 vec", a_vec, expA);
    a_in_valid = 1'b0;
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 8'h7F;
    tick();
    a_wr_en = 1'b0;
    expA[5*8 +: 8] = 8'h7F;
    chk("A3 wr vec", a_vec, expA);
    chk("A3 wr full", 168'(a_full), 168'(1));
    chk("A3 wr done", 168'(a_done), 168'(0));
    chk("A3 wr count", 168'(a_count), 168'(21));

    // ---------------- A4: clear after 10 beats with in_valid high
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_data = 8'(8'h40 + i);
      tick();
    end
    chk("A4 count10", 168'(a_count), 168'(10));
    a_clr = 1'b1; a_in_data = 8'h99;
    #1;
    chk("A4 ready clr", 168'(a_in_ready), 168'(0));
    tick();
    a_clr = 1'b0;
    chk("A4 vec zero", a_vec, '0);
    chk("A4 count zero", 168'(a_count), 168'(0));
    chk("A4 full zero", 168'(a_full), 168'(0));
    a_in_data = 8'h33;
    tick();
    expA = '0;
    expA[7:0] = 8'h33;
    chk("A4 entry0", a_vec, expA);
    chk("A4 count1", 168'(a_count), 168'(1));

    // ---------------- A5: simultaneous stream and addressed write
    a_in_data = 8'h01; tick();
    a_in_data = 8'h02; tick();
    expA[15:8] = 8'h01; expA[23:16] = 8'h02;
    chk("A5 count3", 168'(a_count), 168'(3));
    a_in_data = 8'h11;
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 8'h22;
    tick();
    a_in_valid = 1'b0; a_wr_en = 1'b0;
    expA[31:24] = 8'h11;
    chk("A5 same entry", a_vec, expA);
    chk("A5 count4", 168'(a_count), 168'(4));
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 8'h0A; tick();
    a_in_data = 8'h0B; tick();
    a_in_data = 8'h0C; tick();
    a_in_data = 8'h11;
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 8'h22;
    tick();
    a_in_valid = 1'b0; a_wr_en = 1'b0;
    expA = '0;
    expA[7:0] = 8'h0A; expA[15:8] = 8'h0B; expA[23:16] = 8'h0C;
    expA[31:24] = 8'h11; expA[63:56] = 8'h22;
    chk("A5 diff entries", a_vec, expA);

    // ---------------- A6: out-of-range write dropped; reset beats writes
    a_wr_en = 1'b1; a_wr_addr = 5'd30; a_wr_data = 8'h55;
    tick();
    a_wr_en = 1'b0;
    chk("A6 oob vec", a_vec, expA);
    chk("A6 oob count", 168'(a_count), 168'(4));
    a_rst = 1'b1; a_wr_en = 1'b1; a_wr_addr = 5'd2; a_wr_data = 8'hFF;
    a_in_valid = 1'b1; a_in_data = 8'hEE;
    tick();
    a_rst = 1'b0; a_wr_en = 1'b0; a_in_valid = 1'b0;
    chk("A6 rst prio vec", a_vec, '0);
    chk("A6 rst prio count", 168'(a_count), 168'(0));

    // ---------------- B2: DW=16 DEPTH=4 fill
    chk("B1 vec", 168'(b_vec), '0);
    chk("B1 in_ready", 168'(b_in_ready), 168'(1));
    b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_data = 16'(16'h1001 + i);
      tick();
      expB[i*16 +: 16] = 16'(16'h1001 + i);
      chk("B2 count", 168'(b_count), 168'(i + 1));
      if (i < 3) chk("B2 done low", 168'(b_done), 168'(0));
    end
    chk("B2 vec", 168'(b_vec), 168'(expB));
    chk("B2 full", 168'(b_full), 168'(1));
    chk("B2 done", 168'(b_done), 168'(1));
    chk("B2 in_ready", 168'(b_in_ready), 168'(0));
    b_in_data = 16'hAAAA;
    tick();
    chk("B2 done drop", 168'(b_done), 168'(0));
    chk("B2 full hold", 168'(b_full), 168'(1));
    chk("B2 vec hold", 168'(b_vec), 168'(expB));

    // ---------------- B4: mid-fill clear with in_valid high
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    b_in_data = 16'h0101; tick();
    b_in_data = 16'h0202; tick();
    chk("B4 count2", 168'(b_count), 168'(2));
    b_clr = 1'b1; b_in_data = 16'h9999;
    #1;
    chk("B4 ready clr", 168'(b_in_ready), 168'(0));
    tick();
    b_clr = 1'b0;
    chk("B4 vec zero", 168'(b_vec), '0);
    chk("B4 count zero", 168'(b_count), 168'(0));
    b_in_data = 16'h0033;
    tick();
    chk("B4 entry0", 168'(b_vec), 168'(64'h0033));
    chk("B4 count1", 168'(b_count), 168'(1));

    // ---------------- B7: clear on the final beat suppresses done
    b_in_data = 16'h0044; tick();
    b_in_data = 16'h0055; tick();
    chk("B7 count3", 168'(b_count), 168'(3));
    b_in_data = 16'h0066; b_clr = 1'b1;
    tick();
    b_clr = 1'b0; b_in_valid = 1'b0;
    chk("B7 count", 168'(b_count), 168'(0));
    chk("B7 full", 168'(b_full), 168'(0));
    chk("B7 done", 168'(b_done), 168'(0));
    chk("B7 vec", 168'(b_vec), '0);
    tick();
    chk("B7 done later", 168'(b_done), 168'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
